// File: rtl/axi_ctrl_pkg.sv
// Shared AXI widths, master codes, write-channel state encoding and master decode.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS        4
`define AXI_IDS_BITS       8
`define AXI_LEN_BITS       4
`define AXI_DATA_BITS      32
`define AXI_STRB_BITS      4
`define AXI_MASTER_BITS    4
`define AXI_MASTER0        4'b0001
`define AXI_MASTER1        4'b0010
`define AXI_DEFAULT_MASTER 4'b0000
`endif

package axi_ctrl_pkg;

   localparam int ID_BITS     = `AXI_ID_BITS;
   localparam int IDS_BITS    = `AXI_IDS_BITS;
   localparam int LEN_BITS    = `AXI_LEN_BITS;
   localparam int DATA_BITS   = `AXI_DATA_BITS;
   localparam int STRB_BITS   = `AXI_STRB_BITS;
   localparam int MASTER_BITS = `AXI_MASTER_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } wc_state_e;

   // SEL_NONE is the zero encoding so a reset owner field reads as "no master".
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_M0   = 2'd1,
      SEL_M1   = 2'd2
   } master_sel_e;

   function automatic master_sel_e decode_master(input logic [IDS_BITS-1:0] id);
      logic [MASTER_BITS-1:0] code;
      code = id[IDS_BITS-1 -: MASTER_BITS];
      if (code == `AXI_MASTER0)      return SEL_M0;
      else if (code == `AXI_MASTER1) return SEL_M1;
      else                           return SEL_NONE;
   endfunction

endpackage

// File: rtl/write_channel_ctrl_b_router.sv
// Combinational B-channel steer: slave response to the owning master, or sunk
// when the ID carries an unknown master code.
module b_router
   import axi_ctrl_pkg::*;
(
   input  logic                i_en,
   input  logic [IDS_BITS-1:0] i_bid,
   input  logic [1:0]          i_bresp,
   input  logic                i_bvalid,
   output logic                o_bready,
   input  logic                i_bready_m0,
   input  logic                i_bready_m1,
   output logic [ID_BITS-1:0]  o_bid_m0,
   output logic [1:0]          o_bresp_m0,
   output logic                o_bvalid_m0,
   output logic [ID_BITS-1:0]  o_bid_m1,
   output logic [1:0]          o_bresp_m1,
   output logic                o_bvalid_m1,
   output logic                o_sink
);

   always_comb begin
      o_bready    = 1'b0;
      o_bid_m0    = '0;
      o_bresp_m0  = 2'b00;
      o_bvalid_m0 = 1'b0;
      o_bid_m1    = '0;
      o_bresp_m1  = 2'b00;
      o_bvalid_m1 = 1'b0;
      o_sink      = 1'b0;
      if (i_en) begin
         case (decode_master(i_bid))
            SEL_M0: begin
               o_bid_m0    = i_bid[ID_BITS-1:0];
               o_bresp_m0  = i_bresp;
               o_bvalid_m0 = i_bvalid;
               o_bready    = i_bready_m0;
            end
            SEL_M1: begin
               o_bid_m1    = i_bid[ID_BITS-1:0];
               o_bresp_m1  = i_bresp;
               o_bvalid_m1 = i_bvalid;
               o_bready    = i_bready_m1;
            end
            default: begin
               o_bready = 1'b1;
               o_sink   = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/write_channel_ctrl.sv
// W/B sequencer behind the AW arbiter: locks W to the AW owner for LEN+1 beats,
// generates WLAST, then routes the B response back.
//   state | meaning
//   IDLE  | no write outstanding, W/B outputs 0, AW grants allowed
//   DATA  | W routed from the latched owner, beats counted
//   RESP  | waiting for the slave B response, routed by bid
module write_channel_ctrl
   import axi_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 aw_fire_i,
   input  logic [IDS_BITS-1:0]  aw_id_i,
   input  logic [LEN_BITS-1:0]  aw_len_i,
   output logic                 aw_block_o,
   input  logic [DATA_BITS-1:0] wdata_m0_i,
   input  logic [STRB_BITS-1:0] wstrb_m0_i,
   input  logic                 wlast_m0_i,
   input  logic                 wvalid_m0_i,
   output logic                 wready_m0_o,
   input  logic [DATA_BITS-1:0] wdata_m1_i,
   input  logic [STRB_BITS-1:0] wstrb_m1_i,
   input  logic                 wlast_m1_i,
   input  logic                 wvalid_m1_i,
   output logic                 wready_m1_o,
   output logic [DATA_BITS-1:0] wdata_s_o,
   output logic [STRB_BITS-1:0] wstrb_s_o,
   output logic                 wlast_s_o,
   output logic                 wvalid_s_o,
   input  logic                 wready_s_i,
   input  logic [IDS_BITS-1:0]  bid_s_i,
   input  logic [1:0]           bresp_s_i,
   input  logic                 bvalid_s_i,
   output logic                 bready_s_o,
   output logic [ID_BITS-1:0]   bid_m0_o,
   output logic [1:0]           bresp_m0_o,
   output logic                 bvalid_m0_o,
   input  logic                 bready_m0_i,
   output logic [ID_BITS-1:0]   bid_m1_o,
   output logic [1:0]           bresp_m1_o,
   output logic                 bvalid_m1_o,
   input  logic                 bready_m1_i,
   output logic                 err_o
);

   wc_state_e           r_state;
   master_sel_e         r_sel;
   logic [LEN_BITS-1:0] r_len;
   logic [LEN_BITS-1:0] r_cnt;
   logic                r_err;

   master_sel_e w_aw_sel;
   logic        w_last_beat;
   logic        w_owner_wlast;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_b_sink;

   assign w_aw_sel    = decode_master(aw_id_i);
   assign w_last_beat = (r_cnt == r_len);

   always_comb begin
      wdata_s_o     = '0;
      wstrb_s_o     = '0;
      wlast_s_o     = 1'b0;
      wvalid_s_o    = 1'b0;
      wready_m0_o   = 1'b0;
      wready_m1_o   = 1'b0;
      w_owner_wlast = 1'b0;
      if (r_state == DATA) begin
         case (r_sel)
            SEL_M0: begin
               wdata_s_o     = wdata_m0_i;
               wstrb_s_o     = wstrb_m0_i;
               wvalid_s_o    = wvalid_m0_i;
               wlast_s_o     = w_last_beat;
               wready_m0_o   = wready_s_i;
               w_owner_wlast = wlast_m0_i;
            end
            SEL_M1: begin
               wdata_s_o     = wdata_m1_i;
               wstrb_s_o     = wstrb_m1_i;
               wvalid_s_o    = wvalid_m1_i;
               wlast_s_o     = w_last_beat;
               wready_m1_o   = wready_s_i;
               w_owner_wlast = wlast_m1_i;
            end
            default: ;
         endcase
      end
   end

   assign w_w_hs = wvalid_s_o & wready_s_i;

   b_router u_b_router (
      .i_en        (r_state == RESP),
      .i_bid       (bid_s_i),
      .i_bresp     (bresp_s_i),
      .i_bvalid    (bvalid_s_i),
      .o_bready    (bready_s_o),
      .i_bready_m0 (bready_m0_i),
      .i_bready_m1 (bready_m1_i),
      .o_bid_m0    (bid_m0_o),
      .o_bresp_m0  (bresp_m0_o),
      .o_bvalid_m0 (bvalid_m0_o),
      .o_bid_m1    (bid_m1_o),
      .o_bresp_m1  (bresp_m1_o),
      .o_bvalid_m1 (bvalid_m1_o),
      .o_sink      (w_b_sink)
   );

   assign w_b_hs = bvalid_s_i & bready_s_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sel   <= SEL_NONE;
         r_len   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (aw_fire_i) begin
                  r_sel <= w_aw_sel;
                  r_len <= aw_len_i;
                  r_cnt <= '0;
                  // Unknown owner: no master may drive W, go straight to wait for B.
                  if (w_aw_sel == SEL_NONE) begin
                     r_state <= RESP;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (aw_fire_i) r_err <= 1'b1;
               if (w_w_hs) begin
                  if (w_owner_wlast != w_last_beat) r_err <= 1'b1;
                  if (w_last_beat) r_state <= RESP;
                  else             r_cnt   <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               if (aw_fire_i || (w_b_sink && bvalid_s_i)) r_err <= 1'b1;
               if (w_b_hs) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign aw_block_o = (r_state != IDLE);
   assign err_o      = r_err;

endmodule

// File: doc/write_channel_ctrl.md
# write_channel_ctrl

Sequences the AXI write-data (W) and write-response (B) channels behind the AW address arbiter. It latches the owner and burst length of each accepted write address, then locks the W channel to that master for exactly LEN+1 beats. It generates WLAST toward the slave, routes the B response back to the owning master, and holds off new AW grants until the transaction completes. The block sits between the two masters' W/B ports and one slave port, alongside the AW arbiter.

## Interface
Parameters: none; all widths come from `AXI_define.svh` (`AXI_ID_BITS`, `AXI_IDS_BITS`, `AXI_LEN_BITS`, `AXI_DATA_BITS`, `AXI_STRB_BITS`, `AXI_MASTER_BITS`, master codes `AXI_MASTER0`, `AXI_MASTER1`, `AXI_DEFAULT_MASTER`).
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- aw_fire_i  in  1  AWVALID&AWREADY at slave this cycle
- aw_id_i  in  AXI_IDS_BITS  slave-side AWID; upper AXI_MASTER_BITS = master code
- aw_len_i  in  AXI_LEN_BITS  AWLEN of accepted burst
- aw_block_o  out  1  high while a write is outstanding; arbiter must not grant AW
- wdata_m{0,1}_i / wstrb_m{0,1}_i / wlast_m{0,1}_i / wvalid_m{0,1}_i  in  DATA/STRB/1/1  master W channels
- wready_m{0,1}_o  out  1  W ready to each master
- wdata_s_o / wstrb_s_o / wlast_s_o / wvalid_s_o  out  DATA/STRB/1/1  W to slave
- wready_s_i  in  1  slave W ready
- bid_s_i / bresp_s_i / bvalid_s_i  in  IDS/2/1  slave B channel
- bready_s_o  out  1  B ready to slave
- bid_m{0,1}_o / bresp_m{0,1}_o / bvalid_m{0,1}_o  out  ID/2/1  B to each master
- bready_m{0,1}_i  in  1  master B ready
- err_o  out  1  one-cycle protocol-error pulse

## Operation
- States:
  - IDLE: all W/B outputs 0.
  - DATA: W routed from the owner.
  - RESP: B routed back to the masters.
- IDLE, aw_fire_i=1: latch owner = aw_id_i[top AXI_MASTER_BITS], len = aw_len_i, cnt = 0; go to DATA.
- DATA: selected master's wdata/wstrb/wvalid drive the slave; wready_owner = wready_s_i, other wready = 0.
  - wlast_s_o = (cnt==len), generated by this block; the master's wlast is not forwarded.
  - On each W handshake: cnt++.
  - On the handshake with cnt==len: go to RESP.
  - err_o pulses on any handshake where the owner's wlast != (cnt==len).
- RESP: decode bid_s_i top bits.
  - Master0/1 code: bvalid to that master, bid_m*_o = bid_s_i low AXI_ID_BITS, bresp passed through, bready_s_o = that master's bready.
  - Any other code: bready_s_o = 1 (response sunk), err_o pulses, no master bvalid.
  - On the B handshake: go to IDLE.
- Owner code not MASTER0/1 at AW latch: err_o pulses; W is sunk (wvalid_s_o=0, no master wready) and the transaction still waits for B.
- aw_fire_i outside IDLE: ignored, err_o pulses.
- aw_block_o = (state != IDLE).
- Counter is AXI_LEN_BITS wide; len=15 gives 16 beats, with no wrap beyond len.

## Timing
- Reset (rst=0, any time, including mid-burst): state IDLE, cnt 0, latched fields 0, err_o 0. Every output is 0, including wlast_s_o and aw_block_o.
- The first W beat can handshake no earlier than the cycle after aw_fire_i. W in the same cycle as aw_fire_i is not accepted.
- W and B paths are combinational pass-through in DATA/RESP, with no added latency per beat.
- aw_block_o rises the cycle after aw_fire_i. It falls the cycle after the B handshake, so the next AW is accepted at the earliest 1 cycle after the B handshake.
- The last-W-beat handshake and bvalid_s_i in the same cycle: B is not routed until RESP (next cycle).
- err_o is registered and pulses the cycle after the offending event.

## Structure
- Shared package `axi_ctrl_pkg`: state enum typedef (IDLE, DATA, RESP) and a master-decode function from an IDS-wide ID. Widths and master codes stay in `AXI_define.svh`.
- One natural sub-module: `b_router`, the combinational B-channel decode/steer from bid_s_i to the two masters or the sink.

## Test plan
- M0 AW id=8'h?5 (M0 code), len=3, slave wready=1 -> 4 beats handshake; wlast_s_o high on beat 4 only; RESP; bresp=2'b00 delivered to M0 with bid_m0_o=4'h5; aw_block_o low 1 cycle after B.
- M1 burst len=0 with wready_s_i toggled 1/0 -> single beat held until ready; wlast_s_o=1 on it; M0 wvalid=1 throughout never sees wready_m0_o.
- M0 asserts wlast on beat 2 of len=3 -> err_o pulses once; transfer continues to 4 beats.
- Slave returns bid with default-master code -> bready_s_o=1, err_o pulse, no bvalid_m*; FSM returns to IDLE.
- rst deasserted-then-asserted low mid-DATA at beat 2 -> all outputs 0 immediately; after release a new AW starts from cnt=0.
- aw_fire_i pulsed during RESP -> ignored, err_o pulse, original B still routed correctly.
